// File: rtl/common.sv
// Shared scalar and bus types used across the pipeline.
// Instruction-bus and fetch-to-decode bundles live here.
package common;

   typedef logic [63:0] u64;

   localparam u64 PCINIT = 64'h8000_0000;

   typedef struct packed {
      logic valid;
      u64   addr;
   } ibus_req_t;

   typedef struct packed {
      logic        data_ok;
      logic [31:0] data;
   } ibus_resp_t;

   typedef struct packed {
      logic        valid;
      u64          pc;
      logic [31:0] raw_instr;
   } fetch_data_t;

endpackage

// File: rtl/pipes.sv
// Pipeline-stage control types.
// Fetch FSM state encoding.
package pipes;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      DISCARD
   } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch stage boundary: instruction bus, decode handoff and redirect.
// master is the fetch side, slave is the bus/decode environment.
interface fetch_if
   import common::*;
   ();

   ibus_req_t   ireq;
   ibus_resp_t  iresp;
   logic        stall;
   logic        redirect;
   u64          redirect_pc;
   fetch_data_t dataF;
   logic        busy;

   modport master (
      output ireq, dataF, busy,
      input  iresp, stall, redirect, redirect_pc
   );

   modport slave (
      input  ireq, dataF, busy,
      output iresp, stall, redirect, redirect_pc
   );

endinterface

// File: rtl/pcreg.sv
// Next-fetch-address register with its reset/redirect/+4 mux.
// Redirect wins over sequential advance; +4 wraps naturally.
module pcreg
   import common::*;
#(
   parameter u64 PC_INIT = PCINIT
) (
   input  logic clk,
   input  logic reset,
   input  logic redirect,
   input  u64   redirect_pc,
   input  logic advance,
   input  u64   base,
   output u64   pc
);

   always_ff @(posedge clk) begin
      if (reset)
         pc <= PC_INIT;
      else if (redirect)
         pc <= redirect_pc;
      else if (advance)
         pc <= base + 64'd4;
   end

endmodule

// File: rtl/fetch.sv
// Instruction fetch stage: one outstanding bus request, one output slot.
// Redirects squash the slot and any in-flight response.
module fetch
   import common::*;
   import pipes::*;
#(
   parameter u64 PC_INIT = PCINIT
) (
   input logic      clk,
   input logic      reset,
   fetch_if.master  bus
);

   fetch_state_t state;
   fetch_data_t  slot;
   logic         req_valid;
   u64           req_addr;
   u64           pc;

   logic consume;
   logic slot_free;
   logic advance;

   assign consume   = slot.valid & ~bus.stall;
   assign slot_free = ~slot.valid | consume;
   assign advance   = (state == FETCH) & bus.iresp.data_ok & ~bus.redirect;

   pcreg #(.PC_INIT(PC_INIT)) u_pcreg (
      .clk         (clk),
      .reset       (reset),
      .redirect    (bus.redirect),
      .redirect_pc (bus.redirect_pc),
      .advance     (advance),
      .base        (req_addr),
      .pc          (pc)
   );

   // The request is held unchanged until data_ok, even across redirects.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         req_valid <= 1'b0;
         req_addr  <= PC_INIT;
         slot      <= '0;
      end else begin
         if (consume || bus.redirect)
            slot.valid <= 1'b0;
         case (state)
            IDLE: begin
               if (slot_free && !bus.redirect) begin
                  req_addr  <= pc;
                  req_valid <= 1'b1;
                  state     <= FETCH;
               end
            end
            FETCH: begin
               if (bus.iresp.data_ok) begin
                  req_valid <= 1'b0;
                  state     <= IDLE;
                  if (!bus.redirect)
                     slot <= '{valid: 1'b1, pc: req_addr,
                               raw_instr: bus.iresp.data};
               end else if (bus.redirect) begin
                  state <= DISCARD;
               end
            end
            DISCARD: begin
               if (bus.iresp.data_ok) begin
                  req_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               req_valid <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

   assign bus.ireq.valid = req_valid;
   assign bus.ireq.addr  = req_addr;
   assign bus.dataF      = slot;
   assign bus.busy       = req_valid;

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage.
// Inputs change and outputs are sampled on the falling edge.
module tb_fetch;
   import common::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   fetch_if bus ();

   fetch #(.PC_INIT(64'h8000_0000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.iresp.data_ok = 1'b0;
      bus.iresp.data    = 32'h0;
      bus.redirect      = 1'b0;
      bus.redirect_pc   = 64'h0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.stall = 1'b0;
      idle_inputs();
      tick();
      tick();
      checks++;
      if (bus.dataF !== '0 || bus.ireq.valid !== 1'b0 || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b busy=%b dataF=%h req 0/0/0",
                  bus.ireq.valid, bus.busy, bus.dataF);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0000
          || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL first_req: valid=%b addr=%h req 1/80000000",
                  bus.ireq.valid, bus.ireq.addr);
      end
   endtask

   task automatic test_fetch();
      tick();
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = 32'h0000_0013;
      tick();
      idle_inputs();
      checks++;
      if (bus.dataF.valid !== 1'b1 || bus.dataF.pc !== 64'h8000_0000
          || bus.dataF.raw_instr !== 32'h0000_0013) begin
         errors++;
         $display("FAIL capture: dataF=%h req 1/80000000/00000013", bus.dataF);
      end
      checks++;
      if (bus.ireq.valid !== 1'b0) begin
         errors++;
         $display("FAIL capture_idle: ireq.valid=%b req 0", bus.ireq.valid);
      end
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0004) begin
         errors++;
         $display("FAIL next_req: valid=%b addr=%h req 1/80000004",
                  bus.ireq.valid, bus.ireq.addr);
      end
   endtask

   task automatic test_stall();
      bus.stall         = 1'b1;
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = 32'h0010_0093;
      tick();
      idle_inputs();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (bus.dataF.valid !== 1'b1 || bus.dataF.pc !== 64'h8000_0004
             || bus.dataF.raw_instr !== 32'h0010_0093
             || bus.ireq.valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold[%0d]: dataF=%h ireq.valid=%b req 1/80000004/00100093 valid 0",
                     i, bus.dataF, bus.ireq.valid);
         end
         tick();
      end
      checks++;
      if (bus.dataF.valid !== 1'b1 || bus.ireq.valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_last: dataF.valid=%b ireq.valid=%b req 1/0",
                  bus.dataF.valid, bus.ireq.valid);
      end
      bus.stall = 1'b0;
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0008
          || bus.dataF.valid !== 1'b0) begin
         errors++;
         $display("FAIL stall_release: valid=%b addr=%h dvalid=%b req 1/80000008/0",
                  bus.ireq.valid, bus.ireq.addr, bus.dataF.valid);
      end
   endtask

   task automatic test_redirect_wait();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 64'h8000_1000;
      tick();
      idle_inputs();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0008
          || bus.busy !== 1'b1) begin
         errors++;
         $display("FAIL discard_hold: valid=%b addr=%h busy=%b req 1/80000008/1",
                  bus.ireq.valid, bus.ireq.addr, bus.busy);
      end
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = 32'hdead_beef;
      tick();
      idle_inputs();
      checks++;
      if (bus.dataF.valid !== 1'b0 || bus.ireq.valid !== 1'b0) begin
         errors++;
         $display("FAIL discard_drop: dvalid=%b ireq.valid=%b req 0/0",
                  bus.dataF.valid, bus.ireq.valid);
      end
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_1000) begin
         errors++;
         $display("FAIL redirect_req: valid=%b addr=%h req 1/80001000",
                  bus.ireq.valid, bus.ireq.addr);
      end
   endtask

   task automatic test_redirect_same();
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = 32'h1111_1111;
      bus.redirect      = 1'b1;
      bus.redirect_pc   = 64'h8000_3000;
      tick();
      idle_inputs();
      checks++;
      if (bus.dataF.valid !== 1'b0 || bus.ireq.valid !== 1'b0) begin
         errors++;
         $display("FAIL same_drop: dvalid=%b ireq.valid=%b req 0/0",
                  bus.dataF.valid, bus.ireq.valid);
      end
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_3000) begin
         errors++;
         $display("FAIL same_req: valid=%b addr=%h req 1/80003000",
                  bus.ireq.valid, bus.ireq.addr);
      end
   endtask

   task automatic test_wrap();
      bus.redirect    = 1'b1;
      bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      tick();
      idle_inputs();
      bus.iresp.data_ok = 1'b1;
      tick();
      idle_inputs();
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_req: valid=%b addr=%h req 1/fffffffffffffffc",
                  bus.ireq.valid, bus.ireq.addr);
      end
      bus.iresp.data_ok = 1'b1;
      bus.iresp.data    = 32'h0000_0013;
      tick();
      idle_inputs();
      checks++;
      if (bus.dataF.valid !== 1'b1 || bus.dataF.pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
         errors++;
         $display("FAIL wrap_capture: dataF=%h req 1/fffffffffffffffc", bus.dataF);
      end
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h0) begin
         errors++;
         $display("FAIL wrap_next: valid=%b addr=%h req 1/0",
                  bus.ireq.valid, bus.ireq.addr);
      end
   endtask

   task automatic test_reset_mid();
      reset = 1'b1;
      tick();
      checks++;
      if (bus.dataF !== '0 || bus.ireq.valid !== 1'b0 || bus.busy !== 1'b0
          || bus.ireq.addr !== 64'h8000_0000) begin
         errors++;
         $display("FAIL reset_mid: valid=%b busy=%b addr=%h dataF=%h req 0/0/80000000/0",
                  bus.ireq.valid, bus.busy, bus.ireq.addr, bus.dataF);
      end
      reset = 1'b0;
      tick();
      checks++;
      if (bus.ireq.valid !== 1'b1 || bus.ireq.addr !== 64'h8000_0000) begin
         errors++;
         $display("FAIL reset_mid_req: valid=%b addr=%h req 1/80000000",
                  bus.ireq.valid, bus.ireq.addr);
      end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_stall();
      test_redirect_wait();
      test_redirect_same();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk input 1 (rising-edge clock); reset input 1 (synchronous, active-high).
REQ-002 SHALL have parameter PC_INIT, default 64'h8000_0000, meaning the first fetch address after reset.
REQ-003 SHALL have port ireq, output, ibus_req_t: instruction-bus request, using the fields valid and addr.
REQ-004 SHALL have port iresp, input, ibus_resp_t: instruction-bus response, using the fields data_ok and data[31:0].
REQ-005 SHALL have port stall, input, 1: the decode stage cannot accept dataF this cycle.
REQ-006 SHALL have port redirect, input, 1: a branch, jump or flush; fetching restarts at redirect_pc.
REQ-007 SHALL have port redirect_pc, input, u64: the restart address.
REQ-008 SHALL have port dataF, output, fetch_data_t {valid, pc, raw_instr}: the registered instruction handed to decode.
REQ-009 SHALL have port busy, output, 1: high while a bus request is outstanding, in state FETCH or DISCARD.

Function
REQ-010 SHALL implement FSM states IDLE, FETCH and DISCARD.
REQ-011 SHALL keep a pc register (next address to fetch) and a req_addr register (address of the in-flight request).
REQ-012 SHALL define consume = dataF.valid & ~stall and slot_free = ~dataF.valid | consume.
REQ-013 In IDLE, SHALL hold ireq.valid=0; if slot_free and ~redirect, it SHALL set req_addr<=pc and go to FETCH.
REQ-014 In FETCH and DISCARD, SHALL drive ireq.valid=1 and ireq.addr=req_addr, both held constant until data_ok; a request, once issued, SHALL never be withdrawn.
REQ-015 In FETCH with data_ok and ~redirect, SHALL do dataF<={1,req_addr,iresp.data}, pc<=req_addr+4, then go to IDLE; request-to-dataF.valid latency is 1 cycle after data_ok.
REQ-016 SHALL issue at most one outstanding request, and a new request only after the previous dataF has been consumed or is being consumed in the same cycle.
REQ-017 On consume without a new capture, SHALL clear dataF.valid at the next edge; dataF SHALL hold all fields stable while valid & stall.
REQ-018 When redirect is high in any state, SHALL clear dataF.valid and set pc<=redirect_pc; redirect SHALL take priority over capture.
REQ-019 On redirect in FETCH without data_ok, SHALL go to DISCARD.
REQ-020 On redirect in FETCH together with data_ok, SHALL drop the data and go to IDLE.
REQ-021 On redirect in IDLE, SHALL stay in IDLE; the redirected fetch starts the next cycle.
REQ-022 In DISCARD, on data_ok SHALL drop the data, leave dataF.valid=0, and go to IDLE; a further redirect while in DISCARD SHALL only update pc.
REQ-023 pc+4 SHALL wrap modulo 2^64; redirect_pc SHALL be used unaltered, with no alignment check.

Reset
REQ-024 On reset, SHALL set state=IDLE, pc=PC_INIT, req_addr=PC_INIT, dataF='0 and ireq.valid=0.
REQ-025 Reset asserted while a request is outstanding SHALL return the block to IDLE; the bus side is reset on the same edge.
REQ-026 After reset deasserts, the first ireq.valid SHALL rise one cycle later, in FETCH, with addr=PC_INIT.

Structure
REQ-027 fetch_state_t SHALL live in package pipes; PC_INIT's default value SHALL be a constant PCINIT in package common; fetch_data_t, ibus_req_t and ibus_resp_t SHALL be the existing shared types.
REQ-028 One sub-module, pcreg, SHALL hold pc and provide the next-pc mux (reset value, +4, redirect_pc).

Verification
REQ-029 Reset, then data_ok with 0x00000013 arriving 2 cycles after the request, stall=0 -> dataF={1,0x80000000,0x00000013}; the next request uses addr 0x80000004.
REQ-030 dataF valid with stall held for 3 cycles -> dataF unchanged and ireq.valid=0 throughout; stall drop -> request for pc+4 the next cycle.
REQ-031 redirect to 0x80001000 while waiting for data_ok -> DISCARD, ireq.addr stays at the old address; the returned data is not shown on dataF; the next request uses 0x80001000.
REQ-032 redirect in the same cycle as data_ok -> dataF.valid=0; the next request uses redirect_pc.
REQ-033 pc=0xFFFF_FFFF_FFFF_FFFC, then capture -> next request addr=0.
REQ-034 reset asserted in the middle of FETCH -> all outputs as in REQ-024 at the next edge.
